// File: rtl/mem_arbiter.sv
// Two-port (core/debug) round-robin arbiter in front of a single-cycle memory.
// Each access runs IDLE/RESP -> ACCESS -> RESP; fsm_state exposes the FSM for debug.
module mem_arbiter #(
  parameter int          WIDTH   = 32,
  parameter logic [31:0] MEM_TOP = 32'h1FFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             c_req,
  input  logic             c_we,
  input  logic             c_byte,
  input  logic [WIDTH-1:0] c_addr,
  input  logic [WIDTH-1:0] c_wdata,
  output logic             c_gnt,
  output logic             c_rvalid,
  output logic             c_err,
  output logic [WIDTH-1:0] c_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic             d_byte,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic             d_err,
  output logic [WIDTH-1:0] d_rdata,
  output logic             mem_we,
  output logic             mem_type,
  output logic [WIDTH-1:0] mem_a,
  output logic [WIDTH-1:0] mem_wd,
  input  logic [WIDTH-1:0] mem_rd,
  output logic [1:0]       fsm_state
);

  // Handshake: a requester holds req and its command stable until it samples
  // gnt high; gnt is a one-cycle pulse and the command is captured in that cycle.
  // The response is rvalid for exactly one cycle, two cycles after gnt.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [WIDTH:0] TOP_X = (WIDTH+1)'(MEM_TOP);

  state_t           state, state_nxt;
  logic             last_dbg;
  logic             any_req, grant_ok, sel_dbg;
  logic             s_we, s_byte, s_err;
  logic [WIDTH-1:0] s_addr, s_wdata;
  logic [WIDTH:0]   addr_x;
  logic             lat_we, lat_byte, lat_err, lat_dbg;
  logic [WIDTH-1:0] lat_addr, lat_wdata;
  logic [WIDTH-1:0] resp_data;

  // Debug wins only if it is alone or core was served last.
  assign any_req  = c_req | d_req;
  assign grant_ok = rst_n & any_req & ((state == IDLE) | (state == RESP));
  assign sel_dbg  = d_req & (~c_req | ~last_dbg);

  assign s_we    = sel_dbg ? d_we    : c_we;
  assign s_byte  = sel_dbg ? d_byte  : c_byte;
  assign s_addr  = sel_dbg ? d_addr  : c_addr;
  assign s_wdata = sel_dbg ? d_wdata : c_wdata;
  assign addr_x  = {1'b0, s_addr};

  // Extra top bit keeps addr+3 from wrapping near the end of the address space.
  always_comb begin
    s_err = 1'b0;
    if (s_byte)
      s_err = (addr_x > TOP_X);
    else
      s_err = (s_addr[1:0] != 2'b00) || ((addr_x + (WIDTH+1)'(3)) > TOP_X);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = grant_ok ? ACCESS : IDLE;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = grant_ok ? ACCESS : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_dbg  <= 1'b1;
      lat_we    <= 1'b0;
      lat_byte  <= 1'b0;
      lat_err   <= 1'b0;
      lat_dbg   <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (grant_ok) begin
      last_dbg  <= sel_dbg;
      lat_we    <= s_we;
      lat_byte  <= s_byte;
      lat_err   <= s_err;
      lat_dbg   <= sel_dbg;
      lat_addr  <= s_addr;
      lat_wdata <= s_wdata;
    end
  end

  assign resp_data = (lat_err | lat_we) ? '0 : mem_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_rdata <= '0;
      c_err   <= 1'b0;
      d_rdata <= '0;
      d_err   <= 1'b0;
    end else if (state == ACCESS) begin
      if (lat_dbg) begin
        d_rdata <= resp_data;
        d_err   <= lat_err;
      end else begin
        c_rdata <= resp_data;
        c_err   <= lat_err;
      end
    end
  end

  always_comb begin
    c_gnt     = grant_ok & ~sel_dbg;
    d_gnt     = grant_ok & sel_dbg;
    c_rvalid  = (state == RESP) & ~lat_dbg;
    d_rvalid  = (state == RESP) & lat_dbg;
    mem_we    = (state == ACCESS) & lat_we & ~lat_err;
    mem_type  = lat_byte;
    mem_a     = lat_addr;
    mem_wd    = lat_wdata;
    fsm_state = state;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: byte-array memory, grant-order reference
// model feeding per-port expected queues, and a negedge monitor.
module tb_mem_arbiter;
  localparam int W   = 32;
  localparam int TOP = 32'h1FFFF;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         c_req, c_we, c_byte, d_req, d_we, d_byte;
  logic [W-1:0] c_addr, c_wdata, d_addr, d_wdata;
  logic         c_gnt, c_rvalid, c_err, d_gnt, d_rvalid, d_err;
  logic [W-1:0] c_rdata, d_rdata;
  logic         mem_we, mem_type;
  logic [W-1:0] mem_a, mem_wd, mem_rd;
  logic [1:0]   fsm_state;

  mem_arbiter #(.WIDTH(W), .MEM_TOP(32'h1FFFF)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_byte(c_byte), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_err(c_err), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_err(d_err), .d_rdata(d_rdata),
    .mem_we(mem_we), .mem_type(mem_type), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_rd(mem_rd), .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory behind the DUT ----------------
  logic [7:0] dmem [0:TOP];
  initial for (int i = 0; i <= TOP; i++) dmem[i] = 8'h00;

  always_comb begin
    mem_rd = '0;
    if (mem_type) begin
      if (mem_a <= TOP) mem_rd = {24'h0, dmem[mem_a]};
    end else if (({1'b0, mem_a} + 33'd3) <= TOP) begin
      mem_rd = {dmem[mem_a + 3], dmem[mem_a + 2], dmem[mem_a + 1], dmem[mem_a]};
    end
  end

  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_type) begin
        if (mem_a <= TOP) dmem[mem_a] <= mem_wd[7:0];
      end else if (({1'b0, mem_a} + 33'd3) <= TOP) begin
        dmem[mem_a]     <= mem_wd[7:0];
        dmem[mem_a + 1] <= mem_wd[15:8];
        dmem[mem_a + 2] <= mem_wd[23:16];
        dmem[mem_a + 3] <= mem_wd[31:24];
      end
    end
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [W:0] exp_c_q[$];
  logic [W:0] exp_d_q[$];
  int         gcyc_c_q[$];
  int         gcyc_d_q[$];

  logic [7:0] model_mem [int unsigned];
  bit         model_last = 1'b1;
  bit         pend_w = 1'b0, pend_byte = 1'b0;
  logic [W-1:0] pend_addr, pend_data;
  bit         prev_gnt = 1'b0, prev_vw = 1'b0;
  bit         spacing_chk = 1'b0, last_g_valid = 1'b0;
  int         last_gcyc = 0;
  int         cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [7:0] mrd(input int unsigned a);
    return model_mem.exists(a) ? model_mem[a] : 8'h00;
  endfunction

  function automatic bit model_err(input bit by, input logic [W-1:0] a);
    longint unsigned la = a;
    if (by) return la > TOP;
    return (a % 4 != 0) || (la + 3 > TOP);
  endfunction

  function automatic logic [W-1:0] model_read(input bit by, input logic [W-1:0] a);
    if (by) return {24'h0, mrd(a)};
    return {mrd(a + 3), mrd(a + 2), mrd(a + 1), mrd(a)};
  endfunction

  task automatic check_resp(input bit p, input logic err, input logic [W-1:0] data);
    logic [W:0] e;
    int         g;
    if ((p ? exp_d_q.size() : exp_c_q.size()) == 0) begin
      n_checks++;
      $display("FAIL rvalid_unexpected: port %0d got rvalid, required none pending", p);
    end else begin
      if (p) begin e = exp_d_q.pop_front(); g = gcyc_d_q.pop_front(); end
      else   begin e = exp_c_q.pop_front(); g = gcyc_c_q.pop_front(); end
      chk(p ? "d_resp" : "c_resp", {err, data}, e);
      chk("latency", cyc - g, 2);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    bit           g, w, we, by, er, vw;
    logic [W-1:0] a, wd;
    logic [W:0]   e;
    cyc++;
    if (!rst_n) begin
      chk("reset_outputs",
          {62'b0, (c_gnt | c_rvalid | c_err | (|c_rdata) | d_gnt | d_rvalid | d_err |
                   (|d_rdata) | mem_we | mem_type | (|mem_a) | (|mem_wd) | (|fsm_state))}, 0);
      exp_c_q.delete(); exp_d_q.delete(); gcyc_c_q.delete(); gcyc_d_q.delete();
      model_last = 1'b1; pend_w = 1'b0; prev_gnt = 1'b0; prev_vw = 1'b0; last_g_valid = 1'b0;
    end else begin
      if (c_rvalid) check_resp(1'b0, c_err, c_rdata);
      if (d_rvalid) check_resp(1'b1, d_err, d_rdata);
      chk("mem_we", mem_we, prev_vw);
      if (pend_w) begin
        if (pend_byte) model_mem[pend_addr] = pend_data[7:0];
        else for (int k = 0; k < 4; k++) model_mem[pend_addr + k] = pend_data[8*k +: 8];
        pend_w = 1'b0;
      end
      g  = c_gnt | d_gnt;
      vw = 1'b0;
      if (g) begin
        w = d_gnt;
        chk("single_gnt", {63'b0, c_gnt & d_gnt}, 0);
        chk("gnt_not_in_access", {63'b0, prev_gnt}, 0);
        chk("gnt_has_req", {63'b0, w ? d_req : c_req}, 1);
        if (c_req && d_req) chk("rr_winner", {63'b0, w}, {63'b0, ~model_last});
        if (spacing_chk && last_g_valid) chk("gnt_spacing", cyc - last_gcyc, 2);
        last_gcyc = cyc; last_g_valid = 1'b1; model_last = w;
        we = w ? d_we : c_we;   by = w ? d_byte : c_byte;
        a  = w ? d_addr : c_addr; wd = w ? d_wdata : c_wdata;
        er = model_err(by, a);
        if (er) e = {1'b1, 32'h0};
        else if (we) begin
          e = {1'b0, 32'h0};
          pend_w = 1'b1; pend_byte = by; pend_addr = a; pend_data = wd;
        end else e = {1'b0, model_read(by, a)};
        vw = we & ~er;
        if (w) begin exp_d_q.push_back(e); gcyc_d_q.push_back(cyc); end
        else   begin exp_c_q.push_back(e); gcyc_c_q.push_back(cyc); end
      end
      prev_gnt = g;
      prev_vw  = vw;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 of the cycle after the grant.
  task automatic issue(input bit p, input bit we, input bit by,
                       input logic [W-1:0] a, input logic [W-1:0] wd);
    bit got = 1'b0;
    if (p) begin d_req = 1; d_we = we; d_byte = by; d_addr = a; d_wdata = wd; end
    else   begin c_req = 1; c_we = we; c_byte = by; c_addr = a; c_wdata = wd; end
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = p ? d_gnt : c_gnt;
    end
    @(posedge clk); #1;
    if (p) d_req = 0; else c_req = 0;
    if (!got) begin
      n_checks++;
      $display("FAIL gnt_timeout: port %0d got no grant, required one within 40 cycles", p);
    end
  endtask

  task automatic rand_op(input bit p);
    bit           we = 1'($urandom_range(0, 1));
    bit           by = ($urandom_range(0, 3) == 0);
    int           r  = $urandom_range(0, 9);
    logic [W-1:0] a;
    if (r == 0)      a = 32'h1FFF8 + $urandom_range(0, 7);
    else if (r == 1) a = 32'h20000 + $urandom_range(0, 3);
    else             a = 32'h10000 + $urandom_range(0, 31);
    if (!by && $urandom_range(0, 4) != 0) a[1:0] = 2'b00;
    issue(p, we, by, a, $urandom);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    c_req = 0; c_we = 0; c_byte = 0; c_addr = '0; c_wdata = '0;
    d_req = 0; d_we = 0; d_byte = 0; d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    @(posedge clk); #1;

    // word write/read, byte reads, boundary and error accesses
    issue(0, 1, 0, 32'h10000, 32'hDEADBEEF);
    issue(0, 0, 0, 32'h10000, 32'h0);
    issue(0, 0, 1, 32'h10003, 32'h0);
    issue(1, 0, 1, 32'h10000, 32'h0);
    issue(0, 0, 0, 32'h10002, 32'h0);
    issue(0, 1, 0, 32'h1FFFE, 32'h12345678);
    issue(1, 0, 1, 32'h20000, 32'h0);
    issue(1, 1, 0, 32'h1FFFC, 32'hCAFEF00D);
    issue(0, 0, 0, 32'h1FFFC, 32'h0);
    issue(0, 1, 1, 32'h1FFFF, 32'h000000AB);
    issue(1, 0, 0, 32'h1FFFC, 32'h0);

    // back-to-back core accesses
    repeat (3) @(posedge clk); #1;
    last_g_valid = 0; spacing_chk = 1;
    for (int i = 0; i < 6; i++) rand_op(0);
    spacing_chk = 0;
    repeat (3) @(posedge clk); #1;

    // both ports requesting continuously across reset release
    rst_n = 0; spacing_chk = 1;
    fork
      begin for (int i = 0; i < 4; i++) rand_op(0); end
      begin for (int i = 0; i < 4; i++) rand_op(1); end
      begin repeat (2) @(posedge clk); #3 rst_n = 1; end
    join
    spacing_chk = 0;
    repeat (3) @(posedge clk); #1;

    // reset during the ACCESS cycle of a write
    issue(0, 1, 0, 32'h10000, 32'hDEADBEEF);
    repeat (3) @(posedge clk); #1;
    issue(0, 1, 0, 32'h10000, 32'h0BADF00D);
    chk("mem_we_in_access", {63'b0, mem_we}, 1);
    rst_n = 0; #1;
    chk("mem_we_async_drop", {63'b0, mem_we}, 0);
    chk("state_async_idle", {62'b0, fsm_state}, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    @(posedge clk); #1;
    issue(0, 0, 0, 32'h10000, 32'h0);

    // random traffic from both ports
    fork
      begin
        for (int i = 0; i < 25; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1 rand_op(0);
        end
      end
      begin
        for (int i = 0; i < 25; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1 rand_op(1);
        end
      end
    join

    for (int i = 0; i < 10 && (exp_c_q.size() + exp_d_q.size()) != 0; i++) @(posedge clk);
    @(posedge clk);
    chk("drain_core", exp_c_q.size(), 0);
    chk("drain_debug", exp_d_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, address/data width.
REQ-002 SHALL have parameter MEM_TOP, default 32'h1FFFF, highest valid byte address.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports c_req/c_we/c_byte  input  1 each  core request, write, byte-size (0 = word).
REQ-006 SHALL have ports c_addr, c_wdata  input  WIDTH  core address, write data.
REQ-007 SHALL have ports c_gnt, c_rvalid, c_err  output  1  core grant pulse, response valid, error flag.
REQ-008 SHALL have port c_rdata  output  WIDTH  core response data.
REQ-009 SHALL have debug-port equivalents d_req, d_we, d_byte, d_addr, d_wdata, d_gnt, d_rvalid, d_err, d_rdata with identical widths and meanings.
REQ-010 SHALL have ports mem_we, mem_type  output  1  memory write enable, byte mode (1 = byte).
REQ-011 SHALL have ports mem_a, mem_wd  output  WIDTH  memory address, write data.
REQ-012 SHALL have port mem_rd  input  WIDTH  combinational memory read data.

Function
REQ-013 SHALL implement the FSM states IDLE, ACCESS, RESP.
REQ-014 SHALL, in IDLE or RESP with any req high, latch the winner's command, pulse its gnt for that one cycle, and go to ACCESS. Otherwise RESP goes to IDLE and IDLE holds.
REQ-015 SHALL, in ACCESS, drive mem_a/mem_wd/mem_type from the latched command and assert mem_we only for a valid write; ACCESS always goes to RESP.
REQ-016 SHALL, at the end of ACCESS, register mem_rd for reads (byte reads already zero-extended by memory), or 0 for writes, into the winner's rdata.
REQ-017 SHALL assert the winner's rvalid for exactly the RESP cycle; latency is req-granted cycle N, memory cycle N+1, rvalid cycle N+2.
REQ-018 SHALL hold rdata/err until the next response to that port.
REQ-019 SHALL require a requester to hold req and command stable until it sees gnt; req high in the gnt cycle counts as a new request only from the next cycle on.
REQ-020 SHALL arbitrate round-robin: a sole requester wins; on conflict, the port not served last wins; the last-served register updates on every grant.
REQ-021 SHALL flag an error when a word access has addr[1:0] != 0, a word access has addr+3 > MEM_TOP, or a byte access has addr > MEM_TOP.
REQ-022 SHALL, on an error, keep mem_we low through ACCESS and return rvalid with err=1 and rdata=0 at the normal latency.
REQ-023 SHALL drive mem_we=0 in all states other than ACCESS.
REQ-024 SHALL drive mem_a, mem_wd, mem_type at their last latched values outside ACCESS, without glitching to requester inputs.
REQ-025 SHALL never grant both ports in the same cycle, and SHALL never assert gnt in ACCESS.

Reset
REQ-026 SHALL, on rst_n low, immediately force state=IDLE and every output to 0, including mem_we (an in-flight write is aborted), and set last-served to debug so the core wins the first conflict.
REQ-027 SHALL, on rst_n deassertion mid-request, treat held reqs as new requests in IDLE without ever completing the pre-reset command.

Verification
REQ-028 Core word write then read: c_req, c_we=1, c_addr=0x10000, c_wdata=0xDEADBEEF, then a read of 0x10000 -> c_gnt each, mem_we high for one cycle, read c_rvalid two cycles after gnt with c_rdata=0xDEADBEEF, c_err=0.
REQ-029 Conflict: both req held continuously after reset -> grants alternate core, debug, core, debug; one grant every two cycles; no double gnt.
REQ-030 Byte read at 0x10003 of word 0xDEADBEEF -> rdata=0x000000DE.
REQ-031 Errors: word read at 0x10002, word write at 0x1FFFE, byte read at 0x20000 -> err=1, rdata=0, mem_we never high.
REQ-032 Reset during ACCESS of a write: rst_n low same cycle -> mem_we drops asynchronously, no rvalid, memory word unchanged.
REQ-033 Back-to-back: core req re-asserted in RESP -> new gnt in RESP cycle, sustained one access per two cycles.
